// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder.
//   state_t  : controller states (IDLE -> ADD -> DONE -> IDLE)
//   NIBBLE_W : width of the shared adder core, bits consumed per ADD cycle
package nsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

endpackage

// File: rtl/Four_bit_ripple_carryadder.sv
// Four-bit ripple-carry adder used as the per-nibble core.
// Ports:
//   Sum  [3:0] out : A + B + Cin, low four bits
//   Cout       out : carry out of bit 3
//   A    [3:0] in  : operand A
//   B    [3:0] in  : operand B
//   Cin        in  : carry into bit 0
module Four_bit_ripple_carryadder
    import nsa_pkg::*;
(
    output logic [NIBBLE_W-1:0] Sum,
    output logic                Cout,
    input  logic [NIBBLE_W-1:0] A,
    input  logic [NIBBLE_W-1:0] B,
    input  logic                Cin
);

    logic [NIBBLE_W:0] carry;

    assign carry[0] = Cin;

    generate
        for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_fa
            assign Sum[gi]     = A[gi] ^ B[gi] ^ carry[gi];
            assign carry[gi+1] = (A[gi] & B[gi]) | (carry[gi] & (A[gi] ^ B[gi]));
        end
    endgenerate

    assign Cout = carry[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per cycle through a shared
// four-bit ripple-carry core, least-significant nibble first.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (ready only in IDLE)
//   a, b, cin            : operands and carry-in
//   out_valid / out_ready: result handshake (valid only in DONE)
//   sum, cout, overflow  : registered result, held until the next result
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = $clog2(NIBBLES);

    state_t                state_reg;
    logic [WIDTH-1:0]      a_sh_reg;
    logic [WIDTH-1:0]      b_sh_reg;
    logic [WIDTH-1:0]      sum_sh_reg;
    logic                  carry_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic                  a_msb_reg;
    logic                  b_msb_reg;
    logic [WIDTH-1:0]      sum_reg;
    logic                  cout_reg;
    logic                  overflow_reg;

    logic [NIBBLE_W-1:0]   s4;
    logic                  c4;
    logic [WIDTH-1:0]      sum_sh_next;
    logic                  last_nibble;

    Four_bit_ripple_carryadder u_core (
        .Sum  (s4),
        .Cout (c4),
        .A    (a_sh_reg[NIBBLE_W-1:0]),
        .B    (b_sh_reg[NIBBLE_W-1:0]),
        .Cin  (carry_reg)
    );

    // New nibble enters at the top; after NIBBLES shifts nibble 0 sits at the bottom.
    assign sum_sh_next = {s4, sum_sh_reg[WIDTH-1:NIBBLE_W]};
    assign last_nibble = (idx_reg == IDX_W'(NIBBLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            a_sh_reg     <= '0;
            b_sh_reg     <= '0;
            sum_sh_reg   <= '0;
            carry_reg    <= 1'b0;
            idx_reg      <= '0;
            a_msb_reg    <= 1'b0;
            b_msb_reg    <= 1'b0;
            sum_reg      <= '0;
            cout_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= b;
                        carry_reg <= cin;
                        a_msb_reg <= a[WIDTH-1];
                        b_msb_reg <= b[WIDTH-1];
                        idx_reg   <= '0;
                        state_reg <= ADD;
                    end
                end
                ADD: begin
                    carry_reg  <= c4;
                    sum_sh_reg <= sum_sh_next;
                    a_sh_reg   <= a_sh_reg >> NIBBLE_W;
                    b_sh_reg   <= b_sh_reg >> NIBBLE_W;
                    if (last_nibble) begin
                        // Wrap instead of incrementing so idx stays within range.
                        idx_reg      <= '0;
                        // Outputs load only here, so they stay stable under backpressure
                        // and keep the previous result while the next one is being built.
                        sum_reg      <= sum_sh_next;
                        cout_reg     <= c4;
                        overflow_reg <= (a_msb_reg == b_msb_reg) && (s4[NIBBLE_W-1] != a_msb_reg);
                        state_reg    <= DONE;
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid16 = 1'b0, out_ready16 = 1'b0, cin16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        in_ready16, out_valid16, cout16, overflow16;
    logic [15:0] sum16;

    logic        in_valid8 = 1'b0, out_ready8 = 1'b0, cin8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        in_ready8, out_valid8, cout8, overflow8;
    logic [7:0]  sum8;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .cin(cin16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .sum(sum16), .cout(cout16), .overflow(overflow16)
    );

    nibble_serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .overflow(overflow8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic get_in_ready(input bit use8);
        return use8 ? in_ready8 : in_ready16;
    endfunction

    function automatic logic get_out_valid(input bit use8);
        return use8 ? out_valid8 : out_valid16;
    endfunction

    function automatic logic [16:0] get_result(input bit use8);
        return use8 ? {8'h00, cout8, sum8} : {cout16, sum16};
    endfunction

    function automatic logic get_ovf(input bit use8);
        return use8 ? overflow8 : overflow16;
    endfunction

    task automatic drive_in(input bit use8, input logic v, input logic [15:0] av,
                            input logic [15:0] bv, input logic cv);
        if (use8) begin
            in_valid8 = v; a8 = av[7:0]; b8 = bv[7:0]; cin8 = cv;
        end else begin
            in_valid16 = v; a16 = av; b16 = bv; cin16 = cv;
        end
    endtask

    task automatic drive_out_ready(input bit use8, input logic v);
        if (use8) out_ready8 = v;
        else      out_ready16 = v;
    endtask

    // One full transaction; called at #1 after a rising edge.
    task automatic run_op(input bit use8, input logic [15:0] av, input logic [15:0] bv,
                          input logic cv, input int stall, input bit poke, input string tag);
        int          nib;
        int          lat;
        int          sa, sb, ss;
        logic [16:0] full;
        logic [16:0] exp_res;
        logic        exp_ovf;

        nib = use8 ? 2 : 4;
        if (use8) begin
            full    = {9'd0, av[7:0]} + {9'd0, bv[7:0]} + {16'd0, cv};
            exp_res = {8'd0, full[8:0]};
            sa = int'($signed(av[7:0]));
            sb = int'($signed(bv[7:0]));
            ss = sa + sb + int'(cv);
            exp_ovf = (ss > 127) || (ss < -128);
        end else begin
            full    = {1'b0, av} + {1'b0, bv} + {16'd0, cv};
            exp_res = full;
            sa = int'($signed(av));
            sb = int'($signed(bv));
            ss = sa + sb + int'(cv);
            exp_ovf = (ss > 32767) || (ss < -32768);
        end

        check({tag, "_ready_before"}, 32'(get_in_ready(use8)), 32'd1);
        drive_in(use8, 1'b1, av, bv, cv);
        @(posedge clk); #1;
        if (poke) drive_in(use8, 1'b1, ~av, bv ^ 16'h5A5A, ~cv);
        else      drive_in(use8, 1'b0, av, bv, cv);

        lat = 0;
        do begin
            if (poke) check({tag, "_in_ready_busy"}, 32'(get_in_ready(use8)), 32'd0);
            @(posedge clk); #1;
            lat++;
        end while (!get_out_valid(use8) && lat < 20);
        check({tag, "_latency"}, 32'(lat), 32'(nib));

        for (int i = 0; i < stall; i++) begin
            check({tag, "_stall_valid"}, 32'(get_out_valid(use8)), 32'd1);
            check({tag, "_stall_result"}, 32'(get_result(use8)), 32'(exp_res));
            if (poke) check({tag, "_stall_in_ready"}, 32'(get_in_ready(use8)), 32'd0);
            @(posedge clk); #1;
        end

        drive_in(use8, 1'b0, av, bv, cv);
        check({tag, "_result"}, 32'(get_result(use8)), 32'(exp_res));
        check({tag, "_overflow"}, 32'(get_ovf(use8)), 32'(exp_ovf));
        drive_out_ready(use8, 1'b1);
        @(posedge clk); #1;
        drive_out_ready(use8, 1'b0);
        check({tag, "_valid_dropped"}, 32'(get_out_valid(use8)), 32'd0);
        check({tag, "_idle_ready"}, 32'(get_in_ready(use8)), 32'd1);
        check({tag, "_held_in_idle"}, 32'(get_result(use8)), 32'(exp_res));
        $display("op %s w=%0d a=%h b=%h cin=%0d -> cout,sum=%h ovf=%0d", tag, use8 ? 8 : 16,
                 av, bv, cv, get_result(use8), get_ovf(use8));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] va[3];
        logic [15:0] vb[3];
        logic [16:0] exp_b2b;
        int          k_in, k_out, last_acc;
        bit          acc;

        // Reset values
        #2;
        check("rst_in_ready", 32'(in_ready16), 32'd1);
        check("rst_out_valid", 32'(out_valid16), 32'd0);
        check("rst_sum", 32'(sum16), 32'd0);
        check("rst_cout", 32'(cout16), 32'd0);
        check("rst_ovf", 32'(overflow16), 32'd0);
        check("rst8_in_ready", 32'(in_ready8), 32'd1);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, "wrap");
        run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 0, 1'b0, "pos_ovf");
        run_op(1'b0, 16'h8000, 16'h8000, 1'b0, 1, 1'b0, "neg_ovf");
        run_op(1'b0, 16'h1234, 16'h4321, 1'b1, 6, 1'b1, "stall_poke");
        check("stall_poke_sum", 32'(sum16), 32'h5556);

        // Asynchronous reset mid-operation
        drive_in(1'b0, 1'b1, 16'hABCD, 16'h1111, 1'b0);
        @(posedge clk); #1;
        drive_in(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid16), 32'd0);
        check("async_rst_sum", 32'(sum16), 32'd0);
        check("async_rst_in_ready", 32'(in_ready16), 32'd1);
        #9;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_out_valid", 32'(out_valid16), 32'd0);
        run_op(1'b0, 16'h0000, 16'h0000, 1'b1, 0, 1'b0, "cin_only");
        run_op(1'b1, 16'h00FF, 16'h0001, 1'b0, 2, 1'b0, "w8_wrap");
        run_op(1'b1, 16'h007F, 16'h0001, 1'b0, 0, 1'b0, "w8_ovf");

        // Back-to-back with in_valid and out_ready held high
        va[0] = 16'h0102; vb[0] = 16'h0304;
        va[1] = 16'hABCD; vb[1] = 16'h1234;
        va[2] = 16'hFFFF; vb[2] = 16'hFFFF;
        k_in = 0; k_out = 0; last_acc = -1;
        drive_in(1'b0, 1'b1, va[0], vb[0], 1'b0);
        out_ready16 = 1'b1;
        for (int cyc = 0; cyc < 40 && k_out < 3; cyc++) begin
            acc = 1'b0;
            if (out_valid16) begin
                exp_b2b = {1'b0, va[k_out]} + {1'b0, vb[k_out]};
                check("b2b_result", 32'({cout16, sum16}), 32'(exp_b2b));
                $display("op b2b #%0d a=%h b=%h -> cout,sum=%h", k_out, va[k_out], vb[k_out],
                         {cout16, sum16});
                k_out++;
            end
            if (in_ready16 && in_valid16) begin
                if (last_acc >= 0) check("b2b_gap", 32'(cyc - last_acc), 32'd6);
                last_acc = cyc;
                acc = 1'b1;
            end
            @(posedge clk); #1;
            if (acc) begin
                k_in++;
                if (k_in < 3) drive_in(1'b0, 1'b1, va[k_in], vb[k_in], 1'b0);
                else          drive_in(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
            end
        end
        check("b2b_count", 32'(k_out), 32'd3);
        out_ready16 = 1'b0;
        drive_in(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        @(posedge clk); #1;

        // Random operations on both widths
        for (int i = 0; i < 1000; i++) begin
            run_op(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                   1'b0, "rnd16");
        end
        for (int i = 0; i < 1000; i++) begin
            run_op(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                   1'b0, "rnd8");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
